riscv_mem_pipe: RTL

RISCV_MEM_PIPE -- requirements
Module: riscv_mem_pipe

---
 rtl/riscv_mem_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/riscv_mem_pipe.sv
// riscv_mem_pipe: STAGES-deep memory-pipeline register chain with WB stall, exception flush and async reset.
// Build option: define RISCV_MEM_PIPE_BADADDR_EN to carry pc_badaddr through the stages.
module riscv_mem_pipe #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] PC_INIT        = 'h200,
    parameter int              STAGES         = 2,
    parameter int              ILEN           = 32,
    parameter int              EXCEPTION_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_stall,
    input  logic [XLEN-1:0]               ex_pc,
    input  logic                          ex_bubble,
    input  logic [ILEN-1:0]               ex_instr,
    input  logic [EXCEPTION_SIZE-1:0]     ex_exception,
    input  logic [XLEN-1:0]               ex_pc_badaddr,
    input  logic [XLEN-1:0]               ex_r,
    input  logic [XLEN-1:0]               dmem_adr,
    input  logic [EXCEPTION_SIZE-1:0]     wb_exception,
    output logic [XLEN-1:0]               mem_pc,
    output logic [ILEN-1:0]               mem_instr,
    output logic                          mem_bubble,
    output logic [EXCEPTION_SIZE-1:0]     mem_exception,
    output logic [XLEN-1:0]               mem_pc_badaddr,
    output logic [XLEN-1:0]               mem_r,
    output logic [XLEN-1:0]               mem_memadr,
    output logic [$clog2(STAGES+1)-1:0]   mem_inflight,
    output logic                          mem_kill
);

    localparam int CNT_W = $clog2(STAGES + 1);

    logic [XLEN-1:0]           pc_p     [STAGES];
    logic [ILEN-1:0]           instr_p  [STAGES];
    logic                      bubble_p [STAGES];
    logic [EXCEPTION_SIZE-1:0] exc_p    [STAGES];
    logic [XLEN-1:0]           r_p      [STAGES];
    logic [XLEN-1:0]           memadr_p [STAGES];
    logic [STAGES-1:0]         vld_p;
    logic                      advance;

    // A trap leaving the last stage, or one already in WB, flushes the whole chain.
    assign mem_kill = (|wb_exception) | (|exc_p[STAGES-1]);
    assign advance  = !mem_kill && !wb_stall;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [XLEN-1:0]           pc_d;
        logic [ILEN-1:0]           instr_d;
        logic                      bubble_d;
        logic [EXCEPTION_SIZE-1:0] exc_d;
        logic [XLEN-1:0]           r_d;
        logic [XLEN-1:0]           memadr_d;

        if (g == 0) begin : g_head
            assign pc_d     = ex_pc;
            assign instr_d  = ex_instr;
            assign bubble_d = ex_bubble;
            assign exc_d    = ex_exception;
            assign r_d      = ex_r;
            assign memadr_d = dmem_adr;
        end else begin : g_tail
            assign pc_d     = pc_p[g-1];
            assign instr_d  = instr_p[g-1];
            assign bubble_d = bubble_p[g-1];
            assign exc_d    = exc_p[g-1];
            assign r_d      = r_p[g-1];
            assign memadr_d = memadr_p[g-1];
        end

        // Control and PC: flushed by kill (PC held), frozen by stall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pc_p[g]     <= PC_INIT;
                bubble_p[g] <= 1'b1;
                exc_p[g]    <= '0;
            end else if (mem_kill) begin
                bubble_p[g] <= 1'b1;
                exc_p[g]    <= '0;
            end else if (!wb_stall) begin
                pc_p[g]     <= pc_d;
                bubble_p[g] <= bubble_d;
                exc_p[g]    <= exc_d;
            end
        end

        // Payload carries no reset; it is meaningless while the stage is a bubble.
        always_ff @(posedge clk) begin
            if (advance) begin
                instr_p[g]  <= instr_d;
                r_p[g]      <= r_d;
                memadr_p[g] <= memadr_d;
            end
        end

        assign vld_p[g] = !bubble_p[g];
    end

`ifdef RISCV_MEM_PIPE_BADADDR_EN
    logic [XLEN-1:0] badaddr_p [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_badaddr
        logic [XLEN-1:0] badaddr_d;
        if (g == 0) begin : g_head
            assign badaddr_d = ex_pc_badaddr;
        end else begin : g_tail
            assign badaddr_d = badaddr_p[g-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                badaddr_p[g] <= '0;
            end else if (advance) begin
                badaddr_p[g] <= badaddr_d;
            end
        end
    end

    assign mem_pc_badaddr = badaddr_p[STAGES-1];
`else
    logic unused_badaddr;
    assign unused_badaddr = ^ex_pc_badaddr;
    assign mem_pc_badaddr = '0;
`endif

    assign mem_pc        = pc_p[STAGES-1];
    assign mem_instr     = instr_p[STAGES-1];
    assign mem_bubble    = bubble_p[STAGES-1];
    assign mem_exception = exc_p[STAGES-1];
    assign mem_r         = r_p[STAGES-1];
    assign mem_memadr    = memadr_p[STAGES-1];
    assign mem_inflight  = CNT_W'($countones(vld_p));

endmodule
